// File: rtl/vmx_pkg.sv
// Shared definitions for the VMX systolic array: SIMD mode encodings,
// accumulator width derivation and lane-slice index helpers.
package vmx_pkg;

  localparam logic VMX_MODE_LANE = 1'b0;
  localparam logic VMX_MODE_FULL = 1'b1;

  // Partial sums carry a full-precision product per lane.
  function automatic int vmx_acc_w(input int lane_w, input int lanes);
    return 2 * lane_w * lanes;
  endfunction

  function automatic int vmx_lane_lo(input int lane, input int lane_w);
    return lane * lane_w;
  endfunction

  function automatic int vmx_acc_lo(input int lane, input int lane_w);
    return lane * 2 * lane_w;
  endfunction

endpackage

// File: rtl/vmx_simd_mac.sv
// Combinational signed multiply-add for one PE: LANES independent narrow
// lanes or a single full-width lane, wrapping modulo the slice width.
module vmx_simd_mac
  import vmx_pkg::*;
#(
  parameter int LANE_W = 8,
  parameter int LANES  = 2,
  localparam int DATA_W = LANE_W * LANES,
  localparam int ACC_W  = vmx_acc_w(LANE_W, LANES)
) (
  input  logic              mode,
  input  logic [DATA_W-1:0] data,
  input  logic [DATA_W-1:0] weight,
  input  logic [ACC_W-1:0]  sum_in,
  output logic [ACC_W-1:0]  result
);

  logic [ACC_W-1:0] lane_sum;
  logic [ACC_W-1:0] data_x;
  logic [ACC_W-1:0] weight_x;
  logic [ACC_W-1:0] full_sum;

  // Operands are sign-extended to the product width, so a plain unsigned
  // multiply yields the correct two's complement low bits.
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [LANE_W-1:0]   a;
    logic [LANE_W-1:0]   w;
    logic [2*LANE_W-1:0] a_x;
    logic [2*LANE_W-1:0] w_x;
    logic [2*LANE_W-1:0] prod;

    assign a    = data[vmx_lane_lo(g, LANE_W) +: LANE_W];
    assign w    = weight[vmx_lane_lo(g, LANE_W) +: LANE_W];
    assign a_x  = {{LANE_W{a[LANE_W-1]}}, a};
    assign w_x  = {{LANE_W{w[LANE_W-1]}}, w};
    assign prod = a_x * w_x;

    assign lane_sum[vmx_acc_lo(g, LANE_W) +: 2*LANE_W] =
      prod + sum_in[vmx_acc_lo(g, LANE_W) +: 2*LANE_W];
  end

  assign data_x   = {{DATA_W{data[DATA_W-1]}}, data};
  assign weight_x = {{DATA_W{weight[DATA_W-1]}}, weight};
  assign full_sum = data_x * weight_x + sum_in;

  assign result = (mode == VMX_MODE_LANE) ? lane_sum : full_sum;

endmodule

// File: rtl/vmx_pe_simd.sv
// Systolic VMX processing element: double-buffered weight, SIMD multiply-add
// against the upstream partial sum, and registered pass-through of the chain.
module vmx_pe_simd
  import vmx_pkg::*;
#(
  parameter int LANE_W = 8,
  parameter int LANES  = 2,
  parameter int CNT_W  = 8,
  localparam int DATA_W = LANE_W * LANES,
  localparam int ACC_W  = vmx_acc_w(LANE_W, LANES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              simd_mode,
  input  logic              in_valid,
  input  logic              load_valid,
  input  logic [CNT_W-1:0]  load_cnt,
  input  logic              weight_swap,
  input  logic [DATA_W-1:0] data,
  input  logic [ACC_W-1:0]  sum_in,
  output logic              simd_mode_pass,
  output logic              in_valid_pass,
  output logic              load_valid_pass,
  output logic              weight_swap_pass,
  output logic [CNT_W-1:0]  load_cnt_pass,
  output logic [DATA_W-1:0] data_pass,
  output logic [ACC_W-1:0]  sum_out,
  output logic              out_valid
);

  logic [DATA_W-1:0] shadow_w;
  logic [DATA_W-1:0] active_w;
  logic [ACC_W-1:0]  mac_result;
  logic              load_hit;

  assign load_hit = load_valid && (load_cnt == '0);

  vmx_simd_mac #(
    .LANE_W (LANE_W),
    .LANES  (LANES)
  ) u_mac (
    .mode   (simd_mode),
    .data   (data),
    .weight (active_w),
    .sum_in (sum_in),
    .result (mac_result)
  );

  // Swap reads the pre-edge shadow, so a same-cycle load lands only in
  // the shadow and the array can keep loading while it computes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_w <= '0;
      active_w <= '0;
    end else if (en) begin
      if (load_hit) begin
        shadow_w <= data;
      end
      if (weight_swap) begin
        active_w <= shadow_w;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      simd_mode_pass   <= 1'b0;
      in_valid_pass    <= 1'b0;
      load_valid_pass  <= 1'b0;
      weight_swap_pass <= 1'b0;
      load_cnt_pass    <= '0;
      data_pass        <= '0;
      sum_out          <= '0;
      out_valid        <= 1'b0;
    end else if (en) begin
      simd_mode_pass   <= simd_mode;
      in_valid_pass    <= in_valid;
      load_valid_pass  <= load_valid;
      weight_swap_pass <= weight_swap;
      load_cnt_pass    <= load_cnt - CNT_W'(1);
      data_pass        <= data;
      sum_out          <= in_valid ? mac_result : sum_in;
      out_valid        <= in_valid;
    end
  end

endmodule

// File: tb/tb_vmx_pe_simd.sv
// Self-checking bench for vmx_pe_simd: directed scenarios plus randomized
// traffic against an arithmetic reference model of the PE.
module tb_vmx_pe_simd;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        simd_mode;
  logic        in_valid;
  logic        load_valid;
  logic [7:0]  load_cnt;
  logic        weight_swap;
  logic [15:0] data;
  logic [31:0] sum_in;
  logic        simd_mode_pass;
  logic        in_valid_pass;
  logic        load_valid_pass;
  logic        weight_swap_pass;
  logic [7:0]  load_cnt_pass;
  logic [15:0] data_pass;
  logic [31:0] sum_out;
  logic        out_valid;

  int n_vec = 0;
  int n_err = 0;

  // reference model state and expected outputs
  logic [15:0] m_shadow, m_active;
  logic        e_mode, e_inv, e_lv, e_sw, e_ov;
  logic [7:0]  e_cnt;
  logic [15:0] e_data;
  logic [31:0] e_sum;

  vmx_pe_simd dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .en               (en),
    .simd_mode        (simd_mode),
    .in_valid         (in_valid),
    .load_valid       (load_valid),
    .load_cnt         (load_cnt),
    .weight_swap      (weight_swap),
    .data             (data),
    .sum_in           (sum_in),
    .simd_mode_pass   (simd_mode_pass),
    .in_valid_pass    (in_valid_pass),
    .load_valid_pass  (load_valid_pass),
    .weight_swap_pass (weight_swap_pass),
    .load_cnt_pass    (load_cnt_pass),
    .data_pass        (data_pass),
    .sum_out          (sum_out),
    .out_valid        (out_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_mac(input logic mode, input logic [15:0] d,
                                          input logic [15:0] w, input logic [31:0] s);
    logic [31:0] res;
    longint      full;
    res = '0;
    if (mode) begin
      full = longint'($signed(d)) * longint'($signed(w)) + longint'(s);
      res  = full[31:0];
    end else begin
      for (int i = 0; i < 2; i++) begin
        int a, b, c, r;
        a = int'($signed(d[i*8 +: 8]));
        b = int'($signed(w[i*8 +: 8]));
        c = int'(s[i*16 +: 16]);
        r = a * b + c;
        res[i*16 +: 16] = r[15:0];
      end
    end
    return res;
  endfunction

  task automatic model_reset();
    m_shadow = '0; m_active = '0;
    e_mode = 0; e_inv = 0; e_lv = 0; e_sw = 0; e_ov = 0;
    e_cnt = '0; e_data = '0; e_sum = '0;
  endtask

  task automatic model_step();
    if (en) begin
      e_mode = simd_mode;
      e_inv  = in_valid;
      e_lv   = load_valid;
      e_sw   = weight_swap;
      e_cnt  = load_cnt - 8'd1;
      e_data = data;
      e_sum  = in_valid ? ref_mac(simd_mode, data, m_active, sum_in) : sum_in;
      e_ov   = in_valid;
      if (weight_swap) m_active = m_shadow;
      if (load_valid && load_cnt == 8'd0) m_shadow = data;
    end
  endtask

  task automatic idle();
    en = 1; simd_mode = 0; in_valid = 0; load_valid = 0;
    load_cnt = 8'd1; weight_swap = 0; data = '0; sum_in = '0;
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge.
  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    en = 1; simd_mode = 1; in_valid = 1; load_valid = 1; load_cnt = 0;
    weight_swap = 1; data = 16'hA5A5; sum_in = 32'hDEAD_BEEF;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (sum_out !== 32'h0) begin
      n_err++; $display("FAIL reset_sum_out got %h want 0", sum_out);
    end
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_err++; $display("FAIL reset_out_valid got %b want 0", out_valid);
    end
    n_vec++;
    if ({data_pass, load_cnt_pass} !== 24'h0) begin
      n_err++; $display("FAIL reset_data_cnt got %h want 0", {data_pass, load_cnt_pass});
    end
    n_vec++;
    if ({simd_mode_pass, in_valid_pass, load_valid_pass, weight_swap_pass} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_flags got %b want 0000",
               {simd_mode_pass, in_valid_pass, load_valid_pass, weight_swap_pass});
    end
    idle();
    rst_n = 1;
    cyc();
  endtask

  task automatic test_load_compute();
    idle();
    data = 16'h0302; load_valid = 1; load_cnt = 0;
    cyc();
    idle();
    weight_swap = 1;
    cyc();
    idle();
    in_valid = 1; simd_mode = 0; data = 16'h0405; sum_in = 32'h0001_0002;
    cyc();
    n_vec++;
    if (sum_out !== 32'h000D_000C || out_valid !== 1'b1) begin
      n_err++; $display("FAIL lane_mode got %h/%b want 000d000c/1", sum_out, out_valid);
    end
    simd_mode = 1; data = 16'h0002; sum_in = 32'd5;
    cyc();
    n_vec++;
    if (sum_out !== 32'h0000_0609) begin
      n_err++; $display("FAIL full_mode got %h want 00000609", sum_out);
    end
    in_valid = 0; sum_in = 32'h1234_5678;
    cyc();
    n_vec++;
    if (sum_out !== 32'h1234_5678 || out_valid !== 1'b0) begin
      n_err++; $display("FAIL passthrough got %h/%b want 12345678/0", sum_out, out_valid);
    end
  endtask

  task automatic test_lane_wrap();
    idle();
    data = 16'h7F7F; load_valid = 1; load_cnt = 0;
    cyc();
    idle();
    weight_swap = 1;
    cyc();
    idle();
    in_valid = 1; data = 16'h7F7F; sum_in = 32'h7FFF_7FFF;
    cyc();
    n_vec++;
    if (sum_out !== 32'hBF00_BF00) begin
      n_err++; $display("FAIL lane_wrap got %h want bf00bf00", sum_out);
    end
  endtask

  task automatic test_load_swap_same();
    idle();
    data = 16'h0102; load_valid = 1; load_cnt = 0;
    cyc();
    // load B, swap and compute together: compute sees pre-swap active (7F7F)
    idle();
    data = 16'h0305; load_valid = 1; load_cnt = 0; weight_swap = 1;
    cyc();
    idle();
    in_valid = 1; simd_mode = 1; data = 16'h0001; weight_swap = 1;
    cyc();
    n_vec++;
    if (sum_out !== 32'h0000_0102) begin
      n_err++; $display("FAIL swap_takes_old_shadow got %h want 00000102", sum_out);
    end
    weight_swap = 0;
    cyc();
    n_vec++;
    if (sum_out !== 32'h0000_0305) begin
      n_err++; $display("FAIL second_swap got %h want 00000305", sum_out);
    end
    idle();
    data = 16'h0707; load_valid = 1; load_cnt = 3;
    cyc();
    n_vec++;
    if (load_cnt_pass !== 8'h02) begin
      n_err++; $display("FAIL cnt_pass_3 got %h want 02", load_cnt_pass);
    end
    load_cnt = 0; load_valid = 0;
    cyc();
    n_vec++;
    if (load_cnt_pass !== 8'hFF) begin
      n_err++; $display("FAIL cnt_pass_0 got %h want ff", load_cnt_pass);
    end
    idle();
    weight_swap = 1;
    cyc();
    idle();
    in_valid = 1; simd_mode = 1; data = 16'h0001;
    cyc();
    n_vec++;
    if (sum_out !== 32'h0000_0305) begin
      n_err++; $display("FAIL nonzero_cnt_no_capture got %h want 00000305", sum_out);
    end
  endtask

  task automatic test_en_stall();
    logic [31:0] held_sum;
    logic [15:0] held_data;
    int          pulses;
    idle();
    cyc();
    held_sum  = sum_out;
    held_data = data_pass;
    pulses    = 0;
    en = 0; in_valid = 1; simd_mode = 0; data = 16'($urandom);
    sum_in = $urandom; load_valid = 1; load_cnt = 0; weight_swap = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      if (out_valid) pulses++;
      n_vec++;
      if (sum_out !== held_sum || data_pass !== held_data || load_cnt_pass !== 8'h00) begin
        n_err++;
        $display("FAIL en_low_frozen cyc %0d got %h/%h/%h want %h/%h/00", i,
                 sum_out, data_pass, load_cnt_pass, held_sum, held_data);
      end
    end
    en = 1; load_valid = 0; weight_swap = 0;
    cyc();
    if (out_valid) pulses++;
    n_vec++;
    if (sum_out !== e_sum) begin
      n_err++; $display("FAIL en_resume_result got %h want %h", sum_out, e_sum);
    end
    idle();
    repeat (2) begin
      cyc();
      if (out_valid) pulses++;
    end
    n_vec++;
    if (pulses !== 1) begin
      n_err++; $display("FAIL en_single_valid got %0d pulses want 1", pulses);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      en          = ($urandom_range(0, 4) != 0);
      simd_mode   = 1'($urandom);
      in_valid    = 1'($urandom);
      load_valid  = ($urandom_range(0, 2) == 0);
      load_cnt    = 8'($urandom_range(0, 3));
      weight_swap = ($urandom_range(0, 3) == 0);
      data        = 16'($urandom);
      sum_in      = $urandom;
      cyc();
      n_vec++;
      if ({simd_mode_pass, in_valid_pass, load_valid_pass, weight_swap_pass,
           load_cnt_pass, data_pass, sum_out, out_valid} !==
          {e_mode, e_inv, e_lv, e_sw, e_cnt, e_data, e_sum, e_ov}) begin
        n_err++;
        $display("FAIL random[%0d] got %b%b%b%b %h %h %h %b want %b%b%b%b %h %h %h %b", i,
                 simd_mode_pass, in_valid_pass, load_valid_pass, weight_swap_pass,
                 load_cnt_pass, data_pass, sum_out, out_valid,
                 e_mode, e_inv, e_lv, e_sw, e_cnt, e_data, e_sum, e_ov);
      end
    end
  endtask

  task automatic test_reset_midload();
    logic [31:0] s;
    idle();
    data = 16'h1357; load_valid = 1; load_cnt = 0;
    cyc();
    idle();
    weight_swap = 1;
    cyc();
    idle();
    in_valid = 1; simd_mode = 1; data = 16'h2468; load_valid = 1; load_cnt = 0;
    sum_in = 32'h0F0F_0F0F;
    cyc();
    #2;
    rst_n = 0;
    model_reset();
    #1;
    n_vec++;
    if ({sum_out, out_valid, data_pass, load_cnt_pass, in_valid_pass, simd_mode_pass}
        !== 59'h0) begin
      n_err++;
      $display("FAIL async_reset got %h/%b/%h/%h want all 0", sum_out, out_valid,
               data_pass, load_cnt_pass);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    idle();
    s = $urandom;
    in_valid = 1; simd_mode = 0; data = 16'($urandom_range(1, 16'hFFFF)); sum_in = s;
    cyc();
    n_vec++;
    if (sum_out !== s || out_valid !== 1'b1) begin
      n_err++; $display("FAIL post_reset_lane got %h/%b want %h/1", sum_out, out_valid, s);
    end
    s = $urandom;
    simd_mode = 1; sum_in = s;
    cyc();
    n_vec++;
    if (sum_out !== s) begin
      n_err++; $display("FAIL post_reset_full got %h want %h", sum_out, s);
    end
  endtask

  initial begin
    test_reset();
    test_load_compute();
    test_lane_wrap();
    test_load_swap_same();
    test_en_stall();
    test_random();
    test_reset_midload();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
